// File: rtl/fir_avg_pkg.sv
// Shared defaults and width helpers for the multichannel moving-window FIR (sum or mean).
package fir_avg_pkg;

  localparam int DIN_W_DEF     = 16;
  localparam int DOUT_W_DEF    = 24;
  localparam int NCH_DEF       = 4;
  localparam int TAPS_LOG2_DEF = 3;
  localparam int AVG_DEF       = 0;
  localparam int ACC_W_DEF     = DIN_W_DEF + TAPS_LOG2_DEF;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // A TAPS-sample window of DIN_W-bit values cannot exceed DIN_W+TAPS_LOG2 bits.
  function automatic int acc_w(input int din_w, input int taps_log2);
    return din_w + taps_log2;
  endfunction

endpackage

// File: rtl/fir_avg_line.sv
// Per-channel circular sample history; presents the oldest sample, which the next write replaces.
module fir_avg_line
  import fir_avg_pkg::*;
#(
  parameter int DIN_W     = DIN_W_DEF,
  parameter int TAPS_LOG2 = TAPS_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [DIN_W-1:0] din_i,
  output logic [DIN_W-1:0] oldest_o
);

  localparam int unsigned TAPS = 1 << TAPS_LOG2;

  logic [DIN_W-1:0]     hist_q [TAPS];
  logic [TAPS_LOG2-1:0] ptr_q;

  assign oldest_o = hist_q[ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) hist_q[i] <= '0;
      ptr_q <= '0;
    end else if (clear_i) begin
      for (int unsigned i = 0; i < TAPS; i++) hist_q[i] <= '0;
      ptr_q <= '0;
    end else if (we_i) begin
      hist_q[ptr_q] <= din_i;
      ptr_q         <= ptr_q + TAPS_LOG2'(1);
    end
  end

endmodule

// File: rtl/fir_avg_mc.sv
// Multichannel moving-window sum/mean: stage 1 updates the channel accumulator,
// stage 2 scales and registers the result.
module fir_avg_mc
  import fir_avg_pkg::*;
#(
  parameter int DIN_W     = DIN_W_DEF,
  parameter int DOUT_W    = DOUT_W_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int TAPS_LOG2 = TAPS_LOG2_DEF,
  parameter int AVG       = AVG_DEF,
  localparam int CH_W     = ch_w(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DIN_W-1:0]  din,
  input  logic              clear,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [DOUT_W-1:0] dout,
  output logic              err_ch
);

  localparam int              ACC_W = acc_w(DIN_W, TAPS_LOG2);
  localparam int              HALF  = 1 << (TAPS_LOG2 - 1);
  localparam logic [CH_W:0]   NCH_L = (CH_W + 1)'(NCH);

  if (DOUT_W < ACC_W) begin : g_chk_dout
    $error("fir_avg_mc: DOUT_W must be at least DIN_W+TAPS_LOG2");
  end
  if (NCH < 1 || NCH > 16) begin : g_chk_nch
    $error("fir_avg_mc: NCH must be in 1..16");
  end
  if (TAPS_LOG2 < 1 || TAPS_LOG2 > 5) begin : g_chk_taps
    $error("fir_avg_mc: TAPS_LOG2 must be in 1..5");
  end
  if (AVG != 0 && AVG != 1) begin : g_chk_avg
    $error("fir_avg_mc: AVG must be 0 or 1");
  end

  logic                     ch_ok, accept;
  logic [NCH-1:0]           we;
  logic [DIN_W-1:0]         oldest_w [NCH];
  logic signed [DIN_W-1:0]  oldest_sel;
  logic signed [ACC_W-1:0]  acc_q [NCH];
  logic signed [ACC_W-1:0]  acc_sel, acc_d;
  logic                     s1_valid_q;
  logic [CH_W-1:0]          s1_ch_q;
  logic signed [ACC_W-1:0]  s1_acc_q;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W-1:0]  mean;
  logic signed [DOUT_W-1:0] dout_d, dout_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     out_valid_q, err_ch_q;

  assign ch_ok  = {1'b0, in_ch} < NCH_L;
  assign accept = in_valid & ~clear & ch_ok;

  for (genvar g = 0; g < NCH; g++) begin : g_line
    fir_avg_line #(
      .DIN_W    (DIN_W),
      .TAPS_LOG2(TAPS_LOG2)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear),
      .we_i    (we[g]),
      .din_i   (din),
      .oldest_o(oldest_w[g])
    );
  end

  // Accumulators update in the accepting cycle, so a same-channel sample next cycle sees the new value.
  always_comb begin
    oldest_sel = '0;
    acc_sel    = '0;
    we         = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (in_ch == CH_W'(c)) begin
        oldest_sel = oldest_w[c];
        acc_sel    = acc_q[c];
        we[c]      = accept;
      end
    end
    acc_d = acc_sel + ACC_W'($signed(din)) - ACC_W'(oldest_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) acc_q[c] <= '0;
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_acc_q   <= '0;
      err_ch_q   <= 1'b0;
    end else begin
      err_ch_q   <= in_valid & ~clear & ~ch_ok;
      s1_valid_q <= accept;
      if (accept) begin
        s1_ch_q  <= in_ch;
        s1_acc_q <= acc_d;
      end
      for (int unsigned c = 0; c < NCH; c++) begin
        if (clear)      acc_q[c] <= '0;
        else if (we[c]) acc_q[c] <= acc_d;
      end
    end
  end

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    rnd    = {s1_acc_q[ACC_W-1], s1_acc_q} + (ACC_W + 1)'(HALF);
    mean   = ACC_W'(rnd >>> TAPS_LOG2);
    dout_d = (AVG != 0) ? DOUT_W'(mean) : DOUT_W'(s1_acc_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      dout_q      <= '0;
    end else begin
      out_valid_q <= s1_valid_q & ~clear;
      if (s1_valid_q && !clear) begin
        out_ch_q <= s1_ch_q;
        dout_q   <= dout_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign dout      = dout_q;
  assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_fir_avg_mc.sv
// Directed bench for fir_avg_mc: three instances (defaults, AVG=1, NCH=3) against a window-sum scoreboard.
module tb_fir_avg_mc;

  typedef struct {
    int dut;
    int ch;
    int val;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               iv  [3];
  logic [1:0]         ich [3];
  logic [15:0]        idn [3];
  logic               clr [3];
  logic               ov  [3];
  logic [1:0]         chq [3];
  logic signed [23:0] dq  [3];
  logic               er  [3];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mh [3][4][8];
  int   mp [3][4];
  int   nchs [3] = '{4, 4, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_avg_mc u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ch(ich[0]), .din(idn[0]), .clear(clr[0]),
    .out_valid(ov[0]), .out_ch(chq[0]), .dout(dq[0]), .err_ch(er[0]));

  fir_avg_mc #(.AVG(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ch(ich[1]), .din(idn[1]), .clear(clr[1]),
    .out_valid(ov[1]), .out_ch(chq[1]), .dout(dq[1]), .err_ch(er[1]));

  fir_avg_mc #(.NCH(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ch(ich[2]), .din(idn[2]), .clear(clr[2]),
    .out_valid(ov[2]), .out_ch(chq[2]), .dout(dq[2]), .err_ch(er[2]));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      iv[d]  = 1'b0;
      ich[d] = '0;
      idn[d] = '0;
      clr[d] = 1'b0;
    end
  endtask

  task automatic zero_model(input int d);
    for (int c = 0; c < 4; c++) begin
      mp[d][c] = 0;
      for (int k = 0; k < 8; k++) mh[d][c][k] = 0;
    end
  endtask

  task automatic drop_pending(input int d);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].dut == d) sb.delete(k);
  endtask

  task automatic send(input int d, input int ch, input int val);
    int s;
    exp_t e;
    @(negedge clk); #1;
    idle_all();
    iv[d]  = 1'b1;
    ich[d] = ch[1:0];
    idn[d] = val[15:0];
    if (ch < nchs[d]) begin
      mh[d][ch][mp[d][ch]] = val;
      mp[d][ch] = (mp[d][ch] + 1) % 8;
      s = 0;
      for (int k = 0; k < 8; k++) s += mh[d][ch][k];
      e.dut = d;
      e.ch  = ch;
      e.val = (d == 1) ? ((s + 4) >>> 3) : s;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      idle_all();
    end
  endtask

  task automatic do_clear(input int d, input int ch, input int val);
    @(negedge clk); #1;
    idle_all();
    clr[d] = 1'b1;
    iv[d]  = 1'b1;
    ich[d] = ch[1:0];
    idn[d] = val[15:0];
    drop_pending(d);
    zero_model(d);
    @(negedge clk); #1;
    chk("clear_ov_1", ov[d], 0);
    idle_all();
    @(negedge clk); #1;
    chk("clear_ov_2", ov[d], 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 3; d++) begin
        int idx;
        exp_t e;
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (sb[k].dut == d) begin
            idx = k;
            break;
          end
        if (ov[d]) begin
          if (idx < 0) chk($sformatf("spurious_ov_dut%0d", d), ov[d], 0);
          else begin
            e = sb[idx];
            sb.delete(idx);
            chk($sformatf("dout_dut%0d_ch%0d", d, e.ch), dq[d], e.val);
            chk($sformatf("out_ch_dut%0d", d), chq[d], e.ch);
            chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
          end
        end else if (idx >= 0 && sb[idx].cyc <= cyc) begin
          chk($sformatf("missing_ov_dut%0d", d), ov[d], 1);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_all();
    for (int d = 0; d < 3; d++) zero_model(d);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ov_dut%0d", d), ov[d], 0);
      chk($sformatf("rst_dout_dut%0d", d), dq[d], 0);
      chk($sformatf("rst_ch_dut%0d", d), chq[d], 0);
      chk($sformatf("rst_err_dut%0d", d), er[d], 0);
    end
    rst = 1'b0;
    idle(2);

    // impulse on ch0
    send(0, 0, 100);
    repeat (9) send(0, 0, 0);
    idle(3);

    // step + interleave ch1/ch2
    for (int i = 0; i < 10; i++) begin
      send(0, 1, 1000);
      send(0, 2, -10);
    end
    idle(3);

    // extremes on ch3
    repeat (8) send(0, 3, -32768);
    repeat (8) send(0, 3, 32767);
    idle(3);

    // clear with one sample in flight and one presented
    send(0, 0, 5);
    send(0, 0, 5);
    send(0, 1, 9);
    do_clear(0, 0, 3);
    send(0, 0, 7);
    idle(3);

    // reset with one sample in flight and one presented
    send(0, 0, 4);
    send(0, 2, 6);
    @(negedge clk); #1;
    idle_all();
    rst    = 1'b1;
    iv[0]  = 1'b1;
    ich[0] = 2'd0;
    idn[0] = 16'd3;
    sb.delete();
    for (int d = 0; d < 3; d++) zero_model(d);
    @(negedge clk); #1;
    chk("midrst_ov", ov[0], 0);
    chk("midrst_dout", dq[0], 0);
    chk("midrst_ch", chq[0], 0);
    idle_all();
    @(negedge clk); #1;
    rst = 1'b0;
    send(0, 0, 7);
    idle(3);

    // AVG=1 rounding
    send(1, 0, 100);
    send(1, 0, -200);
    idle(3);

    // NCH=3 illegal channel
    send(2, 3, 55);
    @(negedge clk); #1;
    chk("err_pulse", er[2], 1);
    chk("err_no_ov", ov[2], 0);
    idle_all();
    @(negedge clk); #1;
    chk("err_clear", er[2], 0);
    send(2, 0, 21);
    idle(4);

    chk("pending_results", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_avg_mc.md
FIR_AVG_MC -- requirements
Module: fir_avg_mc

Interface
REQ-001 SHALL have parameter DIN_W, default 16, signed input sample width.
REQ-002 SHALL have parameter DOUT_W, default 24, signed output width; elaboration error if DOUT_W < DIN_W+TAPS_LOG2.
REQ-003 SHALL have parameter NCH, default 4, channel count, range 1..16.
REQ-004 SHALL have parameter TAPS_LOG2, default 3, window length TAPS = 2**TAPS_LOG2, range 1..5.
REQ-005 SHALL have parameter AVG, default 0; 0 = window sum, 1 = rounded window mean.
REQ-006 SHALL have clk input, 1 bit, sole clock, rising edge.
REQ-007 SHALL have rst input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have in_valid input, 1 bit, sample present this cycle.
REQ-009 SHALL have in_ch input, CH_W = max(1, clog2(NCH)) bits, channel of the sample.
REQ-010 SHALL have din input, DIN_W bits, signed sample.
REQ-011 SHALL have clear input, 1 bit, synchronous flush of all history.
REQ-012 SHALL have out_valid output, 1 bit, one-cycle result strobe.
REQ-013 SHALL have out_ch output, CH_W bits, channel of the result.
REQ-014 SHALL have dout output, DOUT_W bits, signed result.
REQ-015 SHALL have err_ch output, 1 bit, one-cycle pulse flagging a rejected illegal channel.

Function
REQ-016 SHALL keep, per channel, a circular history of the last TAPS accepted samples and a running accumulator of width DIN_W+TAPS_LOG2.
REQ-017 SHALL accept a sample when in_valid=1, clear=0 and in_ch<NCH; no backpressure, one sample per cycle sustained.
REQ-018 On acceptance, stage 1 SHALL register acc[ch] <= acc[ch] + din - oldest[ch], overwrite oldest[ch] with din, and advance that channel's write pointer modulo TAPS.
REQ-019 Stage 2 SHALL register dout = sign-extended acc when AVG=0, or (acc + 2**(TAPS_LOG2-1)) >>> TAPS_LOG2 (round half up, arithmetic shift) when AVG=1.
REQ-020 Latency SHALL be exactly 2 cycles from accepting edge to out_valid=1; out_ch SHALL equal the accepted in_ch.
REQ-021 Back-to-back samples to the same channel SHALL see the updated accumulator; no stall and no hazard.
REQ-022 Channels SHALL be fully independent; interleaving order SHALL not change any channel's result sequence.
REQ-023 Accumulator arithmetic SHALL never overflow (width per REQ-016); no saturation logic.
REQ-024 When in_valid=1 and in_ch>=NCH, the sample SHALL be dropped, state unchanged, err_ch=1 on the next cycle, no out_valid.
REQ-025 When clear=1, all histories, accumulators and pointers SHALL be zeroed at that edge, and any sample in flight or presented that cycle SHALL be discarded; out_valid SHALL be 0 for the next 2 cycles.
REQ-026 dout and out_ch SHALL hold their last values while out_valid=0.

Reset
REQ-027 While rst=1, out_valid, err_ch, dout, out_ch, all histories, accumulators, pointers and pipeline valids SHALL be 0.
REQ-028 rst asserted mid-operation SHALL abort in-flight samples immediately; the first sample after release SHALL see an all-zero history.

Structure
REQ-029 Package fir_avg_pkg SHALL hold default parameter constants, the CH_W derivation function and the accumulator-width constant.
REQ-030 Per-channel history and pointer storage SHALL be sub-module fir_avg_line, instantiated NCH times via generate; accumulator update and scaling stay in fir_avg_mc.

Verification
REQ-031 Impulse: defaults, ch0 din=100 once, then zeros -> ch0 sums 100 for 8 results, then 0.
REQ-032 Step + interleave: ch1 1000 and ch2 -10 alternating -> ch1 1000,2000..8000 then 8000 steady; ch2 -10..-80 then -80; out_ch correct, latency 2.
REQ-033 Extremes: ch3 din=-32768 x8 -> dout=-262144; then 32767 x8 -> 262136; no wrap.
REQ-034 AVG=1: ch0 sums 100 and -100 -> dout 13 and -12.
REQ-035 NCH=3: in_ch=3 din=55 -> err_ch pulse, no out_valid; a following ch0 sample unaffected.
REQ-036 clear and rst mid-stream, each asserted with one sample in flight and one presented the same cycle -> no out_valid for that sample; next ch0 sample 7 -> dout=7.
